pmem_arbiter_n: RTL and testbench

Parametrised physical-memory arbiter that shares one cache-line memory port among `NUM_CH` cache requestors, for example the I-cache, the D-cache and future prefetch or victim buffers. It supports fixed-priority and round-robin grant modes. It registers the granted request so the memory sees stable address, data and command for the whole transaction. It also produces a pipeline-load enable that is low while any memory traffic is pending. It sits between the caches and the top-level `pmem_*` ports and replaces the two-channel arbiter.

---
 rtl/pmem_arbiter_n.sv | 119 +++++++++++
 tb/tb_pmem_arbiter_n.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pmem_arbiter_n: N-channel cache-line memory arbiter, fixed-priority or    |
// | round-robin, with registered memory command.  Rev 1.0                     |
// +--------------------------------------------------------------------------+
module pmem_arbiter_n #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int BLOCK_W = 128,
  parameter int MODE    = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           ch_read,
  input  logic [NUM_CH-1:0]           ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]    ch_address,
  input  logic [NUM_CH*BLOCK_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]           ch_resp,
  output logic [BLOCK_W-1:0]          ch_rdata,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [ADDR_W-1:0]           pmem_address,
  output logic [BLOCK_W-1:0]          pmem_wdata,
  input  logic                        pmem_resp,
  input  logic [BLOCK_W-1:0]          pmem_rdata,
  output logic                        ld_regs
);

  localparam int               PTR_W     = $clog2(NUM_CH);
  localparam logic [PTR_W-1:0] C_LAST_CH = PTR_W'(NUM_CH - 1);
  localparam logic [PTR_W:0]   C_NUM_CH  = (PTR_W+1)'(NUM_CH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  grant_q;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  w_winner;
  logic [PTR_W-1:0]  w_next_ptr;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_grant_oh;
  logic              w_done;

  assign w_req      = ch_read | ch_write;
  assign w_done     = (state == ST_BUSY) && pmem_resp;
  assign w_grant_oh = NUM_CH'(1) << grant_q;
  assign w_next_ptr = (grant_q == C_LAST_CH) ? '0 : grant_q + 1'b1;

  generate
    if (MODE == 0) begin : g_fixed
      // Scan downward so the lowest requesting index is the last to win.
      always_comb begin
        w_winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (w_req[i]) w_winner = PTR_W'(i);
        end
      end
    end else begin : g_rr
      // Offsets scanned downward: the nearest channel at or after rr_ptr wins.
      always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        sum      = '0;
        idx      = '0;
        w_winner = rr_ptr;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
          sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
          if (sum >= C_NUM_CH) sum = sum - C_NUM_CH;
          idx = sum[PTR_W-1:0];
          if (w_req[idx]) w_winner = idx;
        end
      end
    end
  endgenerate

  assign ch_resp  = w_done ? w_grant_oh : '0;
  assign ch_rdata = pmem_rdata;
  assign ld_regs  = ((state == ST_IDLE) && !(|w_req)) ||
                    (w_done && !(|(w_req & ~w_grant_oh)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      grant_q      <= '0;
      rr_ptr       <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|w_req) begin
            grant_q      <= w_winner;
            pmem_address <= ch_address[w_winner*ADDR_W +: ADDR_W];
            pmem_wdata   <= ch_wdata[w_winner*BLOCK_W +: BLOCK_W];
            pmem_write   <= ch_write[w_winner];
            pmem_read    <= ch_read[w_winner] & ~ch_write[w_winner];
            state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            state      <= ST_IDLE;
            if (MODE == 1) rr_ptr <= w_next_ptr;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter_n.sv
`default_nettype none
// Bench for pmem_arbiter_n: a 2-channel fixed-priority instance and a
// 3-channel round-robin instance, checked against a queue of expected grants.
module tb_pmem_arbiter_n;

  localparam int AW = 16;
  localparam int BW = 32;

  typedef struct {
    int              ch;
    logic [AW-1:0]   addr;
    logic [BW-1:0]   wdata;
    logic            wr;
  } exp_t;

  logic clk;
  logic rst_n;

  logic [1:0]      a_read, a_write, a_resp;
  logic [2*AW-1:0] a_addr;
  logic [2*BW-1:0] a_wdata;
  logic [BW-1:0]   a_rdata, a_pwdata, a_prdata;
  logic [AW-1:0]   a_paddr;
  logic            a_pread, a_pwrite, a_presp, a_ld;

  logic [2:0]      b_read, b_write, b_resp;
  logic [3*AW-1:0] b_addr;
  logic [3*BW-1:0] b_wdata;
  logic [BW-1:0]   b_rdata, b_pwdata, b_prdata;
  logic [AW-1:0]   b_paddr;
  logic            b_pread, b_pwrite, b_presp, b_ld;

  int   compared;
  int   mismatched;
  exp_t q_a[$];
  exp_t q_b[$];

  pmem_arbiter_n #(.NUM_CH(2), .ADDR_W(AW), .BLOCK_W(BW), .MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ch_read(a_read), .ch_write(a_write), .ch_address(a_addr), .ch_wdata(a_wdata),
    .ch_resp(a_resp), .ch_rdata(a_rdata),
    .pmem_read(a_pread), .pmem_write(a_pwrite), .pmem_address(a_paddr),
    .pmem_wdata(a_pwdata), .pmem_resp(a_presp), .pmem_rdata(a_prdata),
    .ld_regs(a_ld)
  );

  pmem_arbiter_n #(.NUM_CH(3), .ADDR_W(AW), .BLOCK_W(BW), .MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ch_read(b_read), .ch_write(b_write), .ch_address(b_addr), .ch_wdata(b_wdata),
    .ch_resp(b_resp), .ch_rdata(b_rdata),
    .pmem_read(b_pread), .pmem_write(b_pwrite), .pmem_address(b_paddr),
    .pmem_wdata(b_pwdata), .pmem_resp(b_presp), .pmem_rdata(b_prdata),
    .ld_regs(b_ld)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_cmd_b(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 10; i++) begin
      if (b_pread | b_pwrite) begin
        ok = 1'b1;
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    compared++;
    if ({a_pread, a_pwrite, a_paddr, a_pwdata, a_resp, a_ld} !== {2'b00, 16'h0, 32'h0, 2'b00, 1'b1}) begin
      mismatched++;
      $display("FAIL reset_a: got rd=%b wr=%b addr=%h wd=%h resp=%b ld=%b, want all zero and ld=1",
               a_pread, a_pwrite, a_paddr, a_pwdata, a_resp, a_ld);
    end
    compared++;
    if ({b_pread, b_pwrite, b_paddr, b_pwdata, b_resp} !== '0) begin
      mismatched++;
      $display("FAIL reset_b: got rd=%b wr=%b addr=%h wd=%h resp=%b, want all zero",
               b_pread, b_pwrite, b_paddr, b_pwdata, b_resp);
    end
    rst_n = 1'b1;
    a_read = 2'b10;
    a_addr[AW +: AW] = 16'h0BEE;
    tick();
    compared++;
    if ({a_pread, a_paddr} !== {1'b1, 16'h0BEE}) begin
      mismatched++;
      $display("FAIL reset_pre_grant: got rd=%b addr=%h, want rd=1 addr=0bee", a_pread, a_paddr);
    end
    tick();
    rst_n   = 1'b0;
    a_presp = 1'b1;
    #1;
    compared++;
    if ({a_pread, a_paddr, a_resp} !== {1'b0, 16'h0, 2'b00}) begin
      mismatched++;
      $display("FAIL reset_async: got rd=%b addr=%h resp=%b, want 0/0000/00", a_pread, a_paddr, a_resp);
    end
    a_presp = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    compared++;
    if ({a_pread, a_paddr} !== {1'b1, 16'h0BEE}) begin
      mismatched++;
      $display("FAIL reset_regrant: got rd=%b addr=%h, want rd=1 addr=0bee", a_pread, a_paddr);
    end
    tick();
    a_presp = 1'b1;
    #1;
    compared++;
    if (a_resp !== 2'b10) begin
      mismatched++;
      $display("FAIL reset_resp: got ch_resp=%b, want 10", a_resp);
    end
    tick();
    a_presp = 1'b0;
    a_read  = 2'b00;
    compared++;
    if (a_pread !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_cmd_clear: got rd=%b, want 0", a_pread);
    end
  endtask

  task automatic test_mode0();
    exp_t e;
    a_read  = 2'b01;
    a_write = 2'b10;
    a_addr[0  +: AW] = 16'h1230;
    a_addr[AW +: AW] = 16'h4560;
    a_wdata[0  +: BW] = 32'h1111_1111;
    a_wdata[BW +: BW] = 32'hCAFE_F00D;
    q_a.push_back('{ch: 0, addr: 16'h1230, wdata: 32'h1111_1111, wr: 1'b0});
    q_a.push_back('{ch: 1, addr: 16'h4560, wdata: 32'hCAFE_F00D, wr: 1'b1});
    #1;
    compared++;
    if (a_ld !== 1'b0) begin
      mismatched++;
      $display("FAIL m0_ld_c0: got ld_regs=%b, want 0", a_ld);
    end
    for (int t = 0; t < 2; t++) begin
      tick();
      e = q_a.pop_front();
      compared++;
      if ({a_pread, a_pwrite, a_paddr, a_pwdata} !== {~e.wr, e.wr, e.addr, e.wdata}) begin
        mismatched++;
        $display("FAIL m0_cmd%0d: got rd=%b wr=%b addr=%h wd=%h, want rd=%b wr=%b addr=%h wd=%h",
                 t, a_pread, a_pwrite, a_paddr, a_pwdata, ~e.wr, e.wr, e.addr, e.wdata);
      end
      tick();
      tick();
      a_presp  = 1'b1;
      a_prdata = 32'h0BAD_BE00 + BW'(t);
      #1;
      compared++;
      if ({a_resp, a_rdata, a_ld} !== {2'(1 << e.ch), 32'h0BAD_BE00 + BW'(t), 1'(t == 1)}) begin
        mismatched++;
        $display("FAIL m0_resp%0d: got resp=%b rdata=%h ld=%b, want resp=%b rdata=%h ld=%b",
                 t, a_resp, a_rdata, a_ld, 2'(1 << e.ch), 32'h0BAD_BE00 + BW'(t), 1'(t == 1));
      end
      tick();
      a_presp = 1'b0;
      if (t == 0) a_read = 2'b00;
      else        a_write = 2'b00;
      #1;
      compared++;
      if ({a_pread, a_pwrite, a_ld} !== {2'b00, 1'(t == 1)}) begin
        mismatched++;
        $display("FAIL m0_idle%0d: got rd=%b wr=%b ld=%b, want 0 0 %b",
                 t, a_pread, a_pwrite, a_ld, 1'(t == 1));
      end
    end
  endtask

  task automatic test_stability();
    a_read = 2'b01;
    a_addr[0 +: AW]  = 16'h2222;
    a_wdata[0 +: BW] = 32'hAAAA_5555;
    tick();
    a_addr[0 +: AW]  = 16'h3333;
    a_wdata[0 +: BW] = 32'h5555_AAAA;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 2) begin
        a_presp = 1'b1;
        #1;
      end
      compared++;
      if ({a_paddr, a_pwdata} !== {16'h2222, 32'hAAAA_5555}) begin
        mismatched++;
        $display("FAIL stable_c%0d: got addr=%h wd=%h, want 2222 aaaa5555", c, a_paddr, a_pwdata);
      end
    end
    tick();
    a_presp = 1'b0;
    a_read  = 2'b00;
  endtask

  task automatic test_conflict();
    a_read  = 2'b10;
    a_write = 2'b10;
    a_addr[AW +: AW] = 16'h7777;
    tick();
    compared++;
    if ({a_pwrite, a_pread, a_paddr} !== {1'b1, 1'b0, 16'h7777}) begin
      mismatched++;
      $display("FAIL conflict: got wr=%b rd=%b addr=%h, want wr=1 rd=0 addr=7777", a_pwrite, a_pread, a_paddr);
    end
    a_presp = 1'b1;
    tick();
    a_presp = 1'b0;
    a_read  = 2'b00;
    a_write = 2'b00;
  endtask

  task automatic test_stray();
    a_presp = 1'b1;
    #1;
    compared++;
    if ({a_resp, a_ld} !== {2'b00, 1'b1}) begin
      mismatched++;
      $display("FAIL stray_resp: got resp=%b ld=%b, want 00 1", a_resp, a_ld);
    end
    tick();
    a_presp = 1'b0;
    a_read  = 2'b01;
    a_addr[0 +: AW] = 16'h0042;
    tick();
    compared++;
    if ({a_pread, a_paddr} !== {1'b1, 16'h0042}) begin
      mismatched++;
      $display("FAIL stray_idle: got rd=%b addr=%h, want rd=1 addr=0042", a_pread, a_paddr);
    end
    a_presp = 1'b1;
    tick();
    a_presp = 1'b0;
    a_read  = 2'b00;
  endtask

  task automatic test_round_robin();
    exp_t e;
    bit   ok;
    int   n;
    int   cnt[3];
    int   ptr;
    ptr = 0;
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    for (int i = 0; i < 6; i++) begin
      e.ch    = ptr;
      e.addr  = AW'(16'h1000 * (ptr + 1) + i / 3);
      e.wdata = 32'hDA7A_0000 | BW'(e.addr);
      e.wr    = (ptr == 1);
      q_b.push_back(e);
      ptr = (ptr + 1) % 3;
    end
    for (int k = 0; k < 3; k++) begin
      b_addr[k*AW +: AW]  = AW'(16'h1000 * (k + 1));
      b_wdata[k*BW +: BW] = 32'hDA7A_0000 | BW'(16'h1000 * (k + 1));
    end
    b_read  = 3'b101;
    b_write = 3'b010;
    for (int i = 0; i < 6; i++) begin
      wait_cmd_b(ok, n);
      compared++;
      if (!ok || (i > 0 && n != 1)) begin
        mismatched++;
        $display("FAIL rr_gap%0d: got ok=%0d idle_cycles=%0d, want command after 1 idle cycle", i, ok, n);
      end
      e = q_b.pop_front();
      compared++;
      if ({b_pread, b_pwrite, b_paddr, b_pwdata} !== {~e.wr, e.wr, e.addr, e.wdata}) begin
        mismatched++;
        $display("FAIL rr_cmd%0d: got rd=%b wr=%b addr=%h wd=%h, want ch%0d rd=%b wr=%b addr=%h wd=%h",
                 i, b_pread, b_pwrite, b_paddr, b_pwdata, e.ch, ~e.wr, e.wr, e.addr, e.wdata);
      end
      tick();
      tick();
      b_presp = 1'b1;
      #1;
      compared++;
      if ({b_resp, b_ld} !== {3'(1 << e.ch), 1'b0}) begin
        mismatched++;
        $display("FAIL rr_resp%0d: got resp=%b ld=%b, want resp=%b ld=0", i, b_resp, b_ld, 3'(1 << e.ch));
      end
      tick();
      b_presp = 1'b0;
      cnt[e.ch]++;
      b_addr[e.ch*AW +: AW]  = AW'(16'h1000 * (e.ch + 1) + cnt[e.ch]);
      b_wdata[e.ch*BW +: BW] = 32'hDA7A_0000 | BW'(16'h1000 * (e.ch + 1) + cnt[e.ch]);
      if (i == 5) begin
        b_read  = 3'b000;
        b_write = 3'b000;
      end
    end
    tick();
    compared++;
    if ({b_pread, b_pwrite, q_b.size()} !== {2'b00, 32'd0}) begin
      mismatched++;
      $display("FAIL rr_end: got rd=%b wr=%b pending=%0d, want idle with 0 pending",
               b_pread, b_pwrite, q_b.size());
    end
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    compared   = 0;
    mismatched = 0;
    a_read = '0; a_write = '0; a_addr = '0; a_wdata = '0; a_presp = 1'b0; a_prdata = '0;
    b_read = '0; b_write = '0; b_addr = '0; b_wdata = '0; b_presp = 1'b0; b_prdata = '0;
    test_reset();
    test_mode0();
    test_stability();
    test_conflict();
    test_stray();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
